// File: rtl/phy_reg_free_list_pkg.sv
// Shared rename-logic sizing for the physical register free list.
// Tags below the architectural register count hold the initial mapping, so they are never free at reset.
package phy_reg_free_list_pkg;

  localparam int unsigned DEF_PHYSICAL_REG_NUM_WIDTH = 6;
  localparam int unsigned DEF_ARCH_REG_NUM_WIDTH     = 5;

  function automatic int unsigned free_list_depth(input int unsigned phy_w,
                                                  input int unsigned arch_w);
    return (32'd1 << phy_w) - (32'd1 << arch_w);
  endfunction

  function automatic int unsigned free_list_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/phy_reg_free_list.sv
// Circular FIFO of free physical register tags.
// The head entry is visible combinationally; allocate and free may both happen in the same cycle.
module phy_reg_free_list
  import phy_reg_free_list_pkg::*;
#(
  parameter int unsigned PHYSICAL_REG_NUM_WIDTH = DEF_PHYSICAL_REG_NUM_WIDTH,
  parameter int unsigned ARCH_REG_NUM_WIDTH     = DEF_ARCH_REG_NUM_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_req,
  output logic                              alloc_valid,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_preg,
  input  logic                              free_valid,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] free_preg,
  output logic [PHYSICAL_REG_NUM_WIDTH:0]   free_count,
  output logic                              overflow_err,
  output logic                              underflow_err
);

  localparam int unsigned NumArch = 32'd1 << ARCH_REG_NUM_WIDTH;
  localparam int unsigned Depth   = free_list_depth(PHYSICAL_REG_NUM_WIDTH, ARCH_REG_NUM_WIDTH);
  localparam int unsigned PtrW    = free_list_ptr_width(Depth);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);
  localparam logic [PHYSICAL_REG_NUM_WIDTH:0] DepthCnt = (PHYSICAL_REG_NUM_WIDTH + 1)'(Depth);

  logic [PHYSICAL_REG_NUM_WIDTH-1:0] entries_q [Depth];
  logic [PtrW-1:0]                   head_q, head_d;
  logic [PtrW-1:0]                   tail_q, tail_d;
  logic [PHYSICAL_REG_NUM_WIDTH:0]   count_q, count_d;
  logic                              overflow_q, underflow_q;
  logic                              do_alloc, do_free;

  assign alloc_valid   = (count_q != '0);
  assign alloc_preg    = entries_q[head_q];
  assign free_count    = count_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  assign do_alloc = alloc_req && alloc_valid;
  assign do_free  = free_valid && (count_q < DepthCnt);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_alloc) begin
      head_d = (head_q == LastIdx) ? '0 : head_q + 1'b1;
    end
    if (do_free) begin
      tail_d = (tail_q == LastIdx) ? '0 : tail_q + 1'b1;
    end
    unique case ({do_alloc, do_free})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   count_d = count_q + 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Tags 0..NumArch-1 are the initial architectural mapping, so the list starts full above them.
      for (int unsigned i = 0; i < Depth; i++) begin
        entries_q[i] <= PHYSICAL_REG_NUM_WIDTH'(NumArch + i);
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= DepthCnt;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_free) begin
        entries_q[tail_q] <= free_preg;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (free_valid && !do_free) begin
        overflow_q <= 1'b1;
      end
      if (alloc_req && !alloc_valid) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule
